// File: rtl/rs_tdp36k_pkg.sv
// Shared definitions for the TDP36K FIFO-mode model: width codes, MODE_BITS
// field positions, geometry helpers and status-bus bit positions.
package rs_tdp36k_pkg;

    localparam logic [2:0] WCODE_36 = 3'b110;
    localparam logic [2:0] WCODE_18 = 3'b010;
    localparam logic [2:0] WCODE_9  = 3'b100;
    localparam logic [2:0] WCODE_4  = 3'b001;
    localparam logic [2:0] WCODE_2  = 3'b011;
    localparam logic [2:0] WCODE_1  = 3'b101;

    localparam int MB_WCODE_HI = 79;
    localparam int MB_WCODE_LO = 77;
    localparam int MB_PF_HI    = 63;
    localparam int MB_PF_LO    = 52;
    localparam int MB_PE_HI    = 51;
    localparam int MB_PE_LO    = 40;

    localparam int MEM_BITS = 36864;

    localparam int FLAG_EMPTY        = 7;
    localparam int FLAG_ALMOST_EMPTY = 6;
    localparam int FLAG_PROG_EMPTY   = 5;
    localparam int FLAG_UNDERFLOW    = 4;
    localparam int FLAG_FULL         = 3;
    localparam int FLAG_ALMOST_FULL  = 2;
    localparam int FLAG_PROG_FULL    = 1;
    localparam int FLAG_OVERFLOW     = 0;

    // Unknown width codes fall back to the 1-bit geometry.
    function automatic int width_of(input logic [2:0] code);
        case (code)
            WCODE_36: return 36;
            WCODE_18: return 18;
            WCODE_9:  return 9;
            WCODE_4:  return 4;
            WCODE_2:  return 2;
            WCODE_1:  return 1;
            default:  return 1;
        endcase
    endfunction

    function automatic int depth_of(input logic [2:0] code);
        case (width_of(code))
            36:      return 1024;
            18:      return 2048;
            9:       return 4096;
            4:       return 8192;
            2:       return 16384;
            default: return 32768;
        endcase
    endfunction

endpackage

// File: rtl/rs_tdp36k_fifo_mem.sv
// 36 Kbit simple dual-port storage seen as W-bit lanes: one write port and a
// registered read port whose output register clears on reset.
module rs_tdp36k_fifo_mem
    import rs_tdp36k_pkg::*;
#(
    parameter int W  = 36,
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_wen,
    input  logic [AW-1:0] i_waddr,
    input  logic [W-1:0]  i_wdata,
    input  logic          i_ren,
    input  logic [AW-1:0] i_raddr,
    output logic [W-1:0]  o_rdata
);

    localparam int LANES = MEM_BITS / W;
    localparam int LAW   = $clog2(LANES);

    logic [W-1:0]   r_mem [LANES];
    logic [LAW-1:0] w_waddr;
    logic [LAW-1:0] w_raddr;

    assign w_waddr = LAW'(i_waddr);
    assign w_raddr = LAW'(i_raddr);

    // Array contents are never reset so the storage maps onto block RAM.
    always_ff @(posedge clk) begin
        if (i_wen) begin
            r_mem[w_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_rdata <= '0;
        end else if (i_ren) begin
            o_rdata <= r_mem[w_raddr];
        end
    end

endmodule

// File: rtl/rs_tdp36k_fifo.sv
// Single-clock FIFO-mode model of the TDP36K primitive: port A writes, port B
// reads with one cycle of latency, and RDATA_A1 carries registered status flags.
module rs_tdp36k_fifo
    import rs_tdp36k_pkg::*;
#(
    parameter logic [80:0] MODE_BITS = 81'h0
) (
    input  logic        CLK_A1,
    input  logic        FLUSH1,
    input  logic        WEN_A1,
    input  logic        REN_B1,
    input  logic [17:0] WDATA_A1,
    input  logic [17:0] WDATA_A2,
    output logic [17:0] RDATA_A1,
    output logic [17:0] RDATA_B1,
    output logic [17:0] RDATA_B2
);

    localparam logic [2:0]  WCODE     = MODE_BITS[MB_WCODE_HI:MB_WCODE_LO];
    localparam int          W         = width_of(WCODE);
    localparam int          D         = depth_of(WCODE);
    localparam int          AW        = $clog2(D);
    localparam logic [15:0] D16       = 16'(D);
    localparam logic [15:0] PF_THRESH = {4'b0, MODE_BITS[MB_PF_HI:MB_PF_LO]};
    localparam logic [15:0] PE_THRESH = {4'b0, MODE_BITS[MB_PE_HI:MB_PE_LO]};

    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [15:0]   r_count;
    logic          r_empty;
    logic          r_aempty;
    logic          r_pempty;
    logic          r_uflow;
    logic          r_full;
    logic          r_afull;
    logic          r_pfull;
    logic          r_oflow;

    logic          w_wr_ok;
    logic          w_rd_ok;
    logic [15:0]   w_count_next;
    logic [35:0]   w_wdata_all;
    logic [W-1:0]  w_wdata;
    logic [W-1:0]  w_rdata;
    logic [35:0]   w_rdata_ext;
    logic          w_unused;

    assign w_wr_ok     = WEN_A1 & ~r_full;
    assign w_rd_ok     = REN_B1 & ~r_empty;
    assign w_wdata_all = {WDATA_A2, WDATA_A1};
    assign w_wdata     = w_wdata_all[W-1:0];
    assign w_unused    = ^w_wdata_all;

    always_comb begin
        w_count_next = r_count;
        if (w_wr_ok && !w_rd_ok) begin
            w_count_next = r_count + 16'd1;
        end else if (w_rd_ok && !w_wr_ok) begin
            w_count_next = r_count - 16'd1;
        end
    end

    // Flags are computed from the post-edge count so they never lag a cycle.
    always_ff @(posedge CLK_A1 or posedge FLUSH1) begin
        if (FLUSH1) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_empty  <= 1'b1;
            r_aempty <= 1'b0;
            r_pempty <= 1'b1;
            r_uflow  <= 1'b0;
            r_full   <= 1'b0;
            r_afull  <= 1'b0;
            r_pfull  <= (PF_THRESH == 16'd0);
            r_oflow  <= 1'b0;
        end else begin
            if (w_wr_ok) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_rd_ok) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count  <= w_count_next;
            r_empty  <= (w_count_next == 16'd0);
            r_aempty <= (w_count_next == 16'd1);
            r_pempty <= (w_count_next <= PE_THRESH);
            r_uflow  <= REN_B1 & r_empty;
            r_full   <= (w_count_next == D16);
            r_afull  <= (w_count_next == D16 - 16'd1);
            r_pfull  <= (w_count_next >= PF_THRESH);
            r_oflow  <= WEN_A1 & r_full;
        end
    end

    rs_tdp36k_fifo_mem #(
        .W  (W),
        .AW (AW)
    ) u_mem (
        .clk     (CLK_A1),
        .rst     (FLUSH1),
        .i_wen   (w_wr_ok),
        .i_waddr (r_wr_ptr),
        .i_wdata (w_wdata),
        .i_ren   (w_rd_ok),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rdata)
    );

    always_comb begin
        w_rdata_ext          = '0;
        w_rdata_ext[W-1:0]   = w_rdata;
    end

    assign RDATA_B1 = w_rdata_ext[17:0];
    assign RDATA_B2 = w_rdata_ext[35:18];

    always_comb begin
        RDATA_A1                    = '0;
        RDATA_A1[FLAG_EMPTY]        = r_empty;
        RDATA_A1[FLAG_ALMOST_EMPTY] = r_aempty;
        RDATA_A1[FLAG_PROG_EMPTY]   = r_pempty;
        RDATA_A1[FLAG_UNDERFLOW]    = r_uflow;
        RDATA_A1[FLAG_FULL]         = r_full;
        RDATA_A1[FLAG_ALMOST_FULL]  = r_afull;
        RDATA_A1[FLAG_PROG_FULL]    = r_pfull;
        RDATA_A1[FLAG_OVERFLOW]     = r_oflow;
    end

endmodule

// File: tb/tb_rs_tdp36k_fifo.sv
// Scoreboard bench for rs_tdp36k_fifo: three instances (36-, 9- and 18-bit
// modes) driven one at a time, checked every cycle against a behavioural model.
module tb_rs_tdp36k_fifo;

    localparam logic [2:0]  C36 = 3'b110;
    localparam logic [2:0]  C9  = 3'b100;
    localparam logic [2:0]  C18 = 3'b010;
    localparam logic [80:0] MODE36 = {1'b1, {4{C36}}, 1'b1, 3'b0, 12'd2048, 12'd4092, 39'b0, 1'b0};
    localparam logic [80:0] MODE9  = {1'b1, {4{C9}},  1'b1, 3'b0, 12'd2048, 12'd4092, 39'b0, 1'b0};
    localparam logic [80:0] MODE18 = {1'b1, {4{C18}}, 1'b1, 3'b0, 12'd4,    12'd1,    39'b0, 1'b0};

    logic        clk = 1'b0;
    logic        flush [3];
    logic        wen   [3];
    logic        ren   [3];
    logic [17:0] wd1   [3];
    logic [17:0] wd2   [3];
    logic [17:0] st    [3];
    logic [17:0] rd1   [3];
    logic [17:0] rd2   [3];

    int          n_err = 0;
    int          n_chk = 0;

    int          mw   [3] = '{36, 9, 18};
    int          md   [3] = '{1024, 4096, 2048};
    int          mpf  [3] = '{2048, 2048, 4};
    int          mpe  [3] = '{4092, 4092, 1};
    int          mcount [3] = '{0, 0, 0};
    logic [35:0] mlast  [3];
    logic [35:0] sb_q [$];

    always #5 clk = ~clk;

    rs_tdp36k_fifo #(.MODE_BITS(MODE36)) u_fifo36 (
        .CLK_A1(clk), .FLUSH1(flush[0]), .WEN_A1(wen[0]), .REN_B1(ren[0]),
        .WDATA_A1(wd1[0]), .WDATA_A2(wd2[0]),
        .RDATA_A1(st[0]), .RDATA_B1(rd1[0]), .RDATA_B2(rd2[0])
    );

    rs_tdp36k_fifo #(.MODE_BITS(MODE9)) u_fifo9 (
        .CLK_A1(clk), .FLUSH1(flush[1]), .WEN_A1(wen[1]), .REN_B1(ren[1]),
        .WDATA_A1(wd1[1]), .WDATA_A2(wd2[1]),
        .RDATA_A1(st[1]), .RDATA_B1(rd1[1]), .RDATA_B2(rd2[1])
    );

    rs_tdp36k_fifo #(.MODE_BITS(MODE18)) u_fifo18 (
        .CLK_A1(clk), .FLUSH1(flush[2]), .WEN_A1(wen[2]), .REN_B1(ren[2]),
        .WDATA_A1(wd1[2]), .WDATA_A2(wd2[2]),
        .RDATA_A1(st[2]), .RDATA_B1(rd1[2]), .RDATA_B2(rd2[2])
    );

    task automatic check(input string tag, input logic [35:0] act, input logic [35:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] exp_status(input int u, input bit uf, input bit of);
        int c;
        c = mcount[u];
        return {c == 0, c == 1, c <= mpe[u], uf, c == md[u], c == md[u] - 1, c >= mpf[u], of};
    endfunction

    function automatic logic [7:0] reset_status(input int u);
        return {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, mpf[u] == 0, 1'b0};
    endfunction

    // One clock of stimulus on instance u, then model update and comparison.
    task automatic cycle(input int u, input bit w, input bit r, input logic [35:0] d);
        bit          ef, ff, wr_ok, rd_ok;
        logic [35:0] mask;
        wen[u] = w;
        ren[u] = r;
        {wd2[u], wd1[u]} = d;
        @(posedge clk);
        #1;
        mask  = 36'((64'd1 << mw[u]) - 64'd1);
        ef    = (mcount[u] == 0);
        ff    = (mcount[u] == md[u]);
        wr_ok = w && !ff;
        rd_ok = r && !ef;
        if (rd_ok) mlast[u] = sb_q.pop_front();
        if (wr_ok) sb_q.push_back(d & mask);
        mcount[u] = mcount[u] + int'(wr_ok) - int'(rd_ok);
        $display("u%0d w=%0b r=%0b d=%h count=%0d rdata=%h status=%h",
                 u, w, r, d, mcount[u], {rd2[u], rd1[u]}, st[u][7:0]);
        check($sformatf("u%0d.rdata", u), {rd2[u], rd1[u]}, mlast[u]);
        check($sformatf("u%0d.status", u), 36'(st[u]), 36'(exp_status(u, r && ef, w && ff)));
        wen[u] = 1'b0;
        ren[u] = 1'b0;
    endtask

    // Pulse FLUSH1 between edges and observe the asynchronous clear.
    task automatic flush_check(input int u);
        flush[u] = 1'b1;
        #2;
        check($sformatf("u%0d.flush_st", u), 36'(st[u]), 36'(reset_status(u)));
        check($sformatf("u%0d.flush_rd", u), {rd2[u], rd1[u]}, 36'h0);
        mcount[u] = 0;
        mlast[u]  = '0;
        sb_q.delete();
        @(posedge clk);
        #1;
        flush[u] = 1'b0;
        check($sformatf("u%0d.flush_hold", u), 36'(st[u]), 36'(reset_status(u)));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 3; i++) begin
            flush[i] = 1'b1;
            wen[i]   = 1'b0;
            ren[i]   = 1'b0;
            wd1[i]   = '0;
            wd2[i]   = '0;
            mlast[i] = '0;
        end
        #2;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("u%0d.reset_st", i), 36'(st[i]), 36'(8'hA0));
            check($sformatf("u%0d.reset_rd", i), {rd2[i], rd1[i]}, 36'h0);
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) flush[i] = 1'b0;
        for (int i = 0; i < 3; i++) cycle(i, 1'b0, 1'b0, 36'h0);

        // 36-bit: two writes, two reads
        sb_q.delete();
        cycle(0, 1'b1, 1'b0, 36'h123456789);
        cycle(0, 1'b1, 1'b0, 36'hABCDEF012);
        cycle(0, 1'b0, 1'b1, 36'h0);
        check("u0.first_rd", {rd2[0], rd1[0]}, 36'h123456789);
        check("u0.aempty", 36'(st[0][6]), 36'h1);
        cycle(0, 1'b0, 1'b1, 36'h0);
        check("u0.second_rd", {rd2[0], rd1[0]}, 36'hABCDEF012);
        check("u0.empty", 36'(st[0][7]), 36'h1);
        cycle(0, 1'b0, 1'b0, 36'h0);

        // 9-bit: fill to full, overflow, then first read
        sb_q.delete();
        for (int i = 0; i < 4096; i++) cycle(1, 1'b1, 1'b0, 36'(i % 512));
        check("u1.full", 36'(st[1][3]), 36'h1);
        cycle(1, 1'b1, 1'b0, 36'h1FF);
        check("u1.overflow", 36'(st[1][0]), 36'h1);
        cycle(1, 1'b0, 1'b0, 36'h0);
        check("u1.overflow_clr", 36'(st[1][0]), 36'h0);
        cycle(1, 1'b0, 1'b1, 36'h0);
        check("u1.first_rd", {rd2[1], rd1[1]}, 36'h0);

        // 18-bit: underflow, programmable thresholds, flush mid-stream
        sb_q.delete();
        cycle(2, 1'b0, 1'b1, 36'h0);
        check("u2.underflow", 36'(st[2][4]), 36'h1);
        cycle(2, 1'b0, 1'b0, 36'h0);
        check("u2.underflow_clr", 36'(st[2][4]), 36'h0);
        for (int i = 0; i < 4; i++) begin
            cycle(2, 1'b1, 1'b0, 36'({$urandom(), $urandom()}));
            if (i == 1) check("u2.pempty_clr", 36'(st[2][5]), 36'h0);
        end
        check("u2.pfull", 36'(st[2][1]), 36'h1);
        cycle(2, 1'b1, 1'b1, 36'({$urandom(), $urandom()}));
        check("u2.pfull_steady", 36'(st[2][1]), 36'h1);
        for (int i = 0; i < 6; i++) cycle(2, 1'b1, 1'b0, 36'({$urandom(), $urandom()}));
        check("u2.count10_pfull", 36'(st[2][1]), 36'h1);
        flush_check(2);
        cycle(2, 1'b1, 1'b0, 36'h2A5A5);
        cycle(2, 1'b0, 1'b1, 36'h0);
        check("u2.post_flush_rd", {rd2[2], rd1[2]}, 36'h2A5A5);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
